// File: rtl/load_pkg.sv
// Shared encodings for the load alignment path: load sizes, completion codes
// and controller states.
package load_pkg;

    typedef enum logic [1:0] {
        LS_ILLEGAL = 2'b00,
        LS_WORD    = 2'b01,
        LS_HALF    = 2'b10,
        LS_BYTE    = 2'b11
    } ls_size_e;

    typedef enum logic [1:0] {
        ERR_OK       = 2'b00,
        ERR_MISALIGN = 2'b01,
        ERR_TIMEOUT  = 2'b10,
        ERR_ILLEGAL  = 2'b11
    } err_e;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'b00,
        ST_WAIT_MEM = 2'b01,
        ST_DONE     = 2'b10
    } state_e;

    // Natural alignment: words on 4-byte, halfwords on 2-byte boundaries.
    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
        case (size)
            LS_WORD: return off != 2'b00;
            LS_HALF: return off[0];
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/load_extract.sv
// Little-endian lane select of a word/halfword/byte out of the raw memory
// word, followed by sign or zero extension to the full data width.
module load_extract
    import load_pkg::*;
#(
    parameter int DATA_W = 32,
    localparam int AW = $clog2(DATA_W / 8)
) (
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic [1:0]        LSCtrl,
    input  logic              ls_signed,
    input  logic [AW-1:0]     addr_lo,
    output logic [DATA_W-1:0] ext_data
);

    logic [AW-1:0]     off;
    logic [DATA_W-1:0] shifted;
    logic              fill;
    int                nbits;

    always_comb begin
        off      = addr_lo;
        nbits    = 0;
        fill     = 1'b0;
        ext_data = '0;
        case (LSCtrl)
            LS_WORD: begin
                nbits    = 32;
                off[1:0] = 2'b00;   // word lanes sit on 4-byte boundaries
            end
            LS_HALF: nbits = 16;
            LS_BYTE: nbits = 8;
            default: nbits = 0;
        endcase
        shifted = mem_rdata >> {off, 3'b000};
        if (nbits != 0)
            fill = ls_signed & shifted[nbits-1];
        for (int i = 0; i < DATA_W; i++)
            ext_data[i] = (i < nbits) ? shifted[i] : fill;
    end

endmodule

// File: rtl/load_align_unit.sv
// Load alignment controller: accepts a load, waits for memory read data with a
// bounded timeout, and returns the aligned/extended result with a status code.
module load_align_unit
    import load_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16,
    localparam int AW = $clog2(DATA_W / 8)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        LSCtrl,
    input  logic              ls_signed,
    input  logic [AW-1:0]     addr_lo,
    input  logic              mem_valid,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] data_out,
    output logic [1:0]        err
);

    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    state_e            state;
    logic [7:0]        wait_cnt;
    logic [1:0]        lsctrl_q;
    logic              signed_q;
    logic [AW-1:0]     addr_q;
    logic [DATA_W-1:0] ext_data;

    load_extract #(.DATA_W(DATA_W)) u_extract (
        .mem_rdata (mem_rdata),
        .LSCtrl    (lsctrl_q),
        .ls_signed (signed_q),
        .addr_lo   (addr_q),
        .ext_data  (ext_data)
    );

    assign req_ready = (state == ST_IDLE);
    assign out_valid = (state == ST_DONE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            wait_cnt <= '0;
            lsctrl_q <= LS_ILLEGAL;
            signed_q <= 1'b0;
            addr_q   <= '0;
            data_out <= '0;
            err      <= ERR_OK;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        lsctrl_q <= LSCtrl;
                        signed_q <= ls_signed;
                        addr_q   <= addr_lo;
                        wait_cnt <= '0;
                        if (LSCtrl == LS_ILLEGAL) begin
                            state    <= ST_DONE;
                            err      <= ERR_ILLEGAL;
                            data_out <= '0;
                        end else if (misaligned(LSCtrl, addr_lo[1:0])) begin
                            state    <= ST_DONE;
                            err      <= ERR_MISALIGN;
                            data_out <= '0;
                        end else begin
                            state <= ST_WAIT_MEM;
                        end
                    end
                end
                ST_WAIT_MEM: begin
                    // Returned data wins over a timeout expiring in the same cycle.
                    if (mem_valid) begin
                        state    <= ST_DONE;
                        err      <= ERR_OK;
                        data_out <= ext_data;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                        if (wait_cnt == TMO_LAST) begin
                            state    <= ST_DONE;
                            err      <= ERR_TIMEOUT;
                            data_out <= '0;
                        end
                    end
                end
                ST_DONE: begin
                    if (out_ready)
                        state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_load_align_unit.sv
// Bench for load_align_unit: a 32-bit and a 64-bit instance run in lockstep on
// shared stimulus and are checked against directed vectors and a reference model.
module tb_load_align_unit;

    localparam int TMO = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic [1:0]  lsctrl;
    logic        ls_signed;
    logic [2:0]  addr_lo;
    logic        mem_valid;
    logic [63:0] mem_rdata;
    logic        out_ready;

    logic        rr32, ov32, rr64, ov64;
    logic [31:0] do32;
    logic [63:0] do64;
    logic [1:0]  err32, err64;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    load_align_unit #(.DATA_W(32), .TIMEOUT(TMO)) u32 (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(rr32),
        .LSCtrl(lsctrl), .ls_signed(ls_signed), .addr_lo(addr_lo[1:0]),
        .mem_valid(mem_valid), .mem_rdata(mem_rdata[31:0]),
        .out_valid(ov32), .out_ready(out_ready), .data_out(do32), .err(err32)
    );

    load_align_unit #(.DATA_W(64), .TIMEOUT(TMO)) u64 (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(rr64),
        .LSCtrl(lsctrl), .ls_signed(ls_signed), .addr_lo(addr_lo),
        .mem_valid(mem_valid), .mem_rdata(mem_rdata),
        .out_valid(ov64), .out_ready(out_ready), .data_out(do64), .err(err64)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: expected {err, data} from the load rules, for a given width.
    function automatic logic [65:0] model(input int w, input logic [1:0] c, input logic s,
                                          input logic [2:0] a, input logic [63:0] rd,
                                          input int delay);
        int nbytes, off;
        logic [63:0] v, m;
        if (c == 2'b00) return {2'b11, 64'd0};
        nbytes = (c == 2'b01) ? 4 : (c == 2'b10) ? 2 : 1;
        if ((int'(a) % nbytes) != 0) return {2'b01, 64'd0};
        if (delay >= TMO) return {2'b10, 64'd0};
        off = (w == 32) ? int'(a) % 4 : int'(a);
        v = rd >> (8 * off);
        m = (64'd1 << (8 * nbytes)) - 64'd1;
        v = v & m;
        if (s && v[8*nbytes-1]) v = v | ~m;
        if (w == 32) v = v & 64'h0000_0000_FFFF_FFFF;
        return {2'b00, v};
    endfunction

    // One complete load: accept, optional memory delay, backpressure, handshake.
    task automatic run_load(input logic [1:0] c, input logic s, input logic [2:0] a,
                            input logic [63:0] rd, input int delay, input int bp,
                            input logic [1:0] e, input logic [31:0] d32, input logic [63:0] d64);
        int n, lat;
        @(negedge clk);
        req_valid = 1'b1; lsctrl = c; ls_signed = s; addr_lo = a;
        check("req_ready32", rr32, 1'b1);
        check("req_ready64", rr64, 1'b1);
        @(negedge clk);
        req_valid = 1'b0;
        lsctrl = 2'($urandom); ls_signed = 1'($urandom); addr_lo = 3'($urandom);
        lat = (e == 2'b00) ? delay + 1 : (e == 2'b10) ? TMO : 0;
        n = 0;
        while (!ov32 && n < 20) begin
            mem_valid = (n == delay);
            mem_rdata = (n == delay) ? rd : {$urandom, $urandom};
            @(negedge clk);
            mem_valid = 1'b0;
            n++;
        end
        check("latency", 64'(n), 64'(lat));
        check("out_valid64", ov64, 1'b1);
        check("err32", err32, e);
        check("err64", err64, e);
        check("data32", do32, d32);
        check("data64", do64, d64);
        for (int i = 0; i < bp; i++) begin
            mem_valid = 1'b1;
            mem_rdata = {$urandom, $urandom};
            @(negedge clk);
            mem_valid = 1'b0;
            check("bp_out_valid", {ov32, ov64}, 2'b11);
            check("bp_req_ready", {rr32, rr64}, 2'b00);
            check("bp_data", {do32, do64[31:0]}, {d32, d64[31:0]});
            check("bp_err", {err32, err64}, {e, e});
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("post_hs_out_valid", {ov32, ov64}, 2'b00);
        check("post_hs_req_ready", {rr32, rr64}, 2'b11);
    endtask

    typedef struct {
        logic [1:0]  c;
        logic        s;
        logic [2:0]  a;
        logic [63:0] rd;
        int          delay;
        int          bp;
        logic [1:0]  e;
        logic [31:0] d32;
        logic [63:0] d64;
    } vec_t;

    vec_t tbl[10];

    initial begin
        logic [65:0] r32, r64;
        logic [1:0]  c;
        logic        s;
        logic [2:0]  a;
        logic [63:0] rd;
        int          dly, bp;

        tbl[0] = '{2'b11, 1'b1, 3'd2, 64'h0000_0000_1280_3456, 0, 0, 2'b00, 32'hFFFF_FF80, 64'hFFFF_FFFF_FFFF_FF80};
        tbl[1] = '{2'b01, 1'b0, 3'd4, 64'h8000_0001_0000_0000, 1, 0, 2'b00, 32'h0000_0000, 64'h0000_0000_8000_0001};
        tbl[2] = '{2'b10, 1'b0, 3'd1, 64'h1234_5678_9ABC_DEF0, 0, 5, 2'b01, 32'h0, 64'h0};
        tbl[3] = '{2'b00, 1'b1, 3'd0, 64'hFFFF_FFFF_FFFF_FFFF, 0, 1, 2'b11, 32'h0, 64'h0};
        tbl[4] = '{2'b01, 1'b1, 3'd2, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 2'b01, 32'h0, 64'h0};
        tbl[5] = '{2'b01, 1'b0, 3'd0, 64'hDEAD_BEEF_DEAD_BEEF, 99, 0, 2'b10, 32'h0, 64'h0};
        tbl[6] = '{2'b10, 1'b1, 3'd6, 64'hABCD_1234_5678_9ABC, 3, 0, 2'b00, 32'h0000_5678, 64'hFFFF_FFFF_FFFF_ABCD};
        tbl[7] = '{2'b10, 1'b0, 3'd2, 64'h0000_0000_8001_0000, 0, 5, 2'b00, 32'h0000_8001, 64'h0000_0000_0000_8001};
        tbl[8] = '{2'b11, 1'b1, 3'd7, 64'hF100_0000_0000_00E2, 2, 0, 2'b00, 32'h0000_0000, 64'hFFFF_FFFF_FFFF_FFF1};
        tbl[9] = '{2'b01, 1'b1, 3'd0, 64'h0000_0000_8765_4321, 0, 0, 2'b00, 32'h8765_4321, 64'hFFFF_FFFF_8765_4321};

        reset = 1'b1; req_valid = 1'b0; lsctrl = 2'b00; ls_signed = 1'b0; addr_lo = '0;
        mem_valid = 1'b0; mem_rdata = '0; out_ready = 1'b0;
        #1;
        check("rst_req_ready", {rr32, rr64}, 2'b11);
        check("rst_out_valid", {ov32, ov64}, 2'b00);
        check("rst_data", {32'(do32), do64[31:0]}, 64'd0);
        check("rst_err", {err32, err64}, 4'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 10; i++)
            run_load(tbl[i].c, tbl[i].s, tbl[i].a, tbl[i].rd, tbl[i].delay, tbl[i].bp,
                     tbl[i].e, tbl[i].d32, tbl[i].d64);

        // Reset while waiting on memory: late read data must not complete anything.
        @(negedge clk);
        req_valid = 1'b1; lsctrl = 2'b01; ls_signed = 1'b0; addr_lo = 3'd0;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("wrst_req_ready", {rr32, rr64}, 2'b11);
        check("wrst_out_valid", {ov32, ov64}, 2'b00);
        check("wrst_data32", do32, 32'd0);
        check("wrst_data64", do64, 64'd0);
        check("wrst_err", {err32, err64}, 4'd0);
        @(negedge clk);
        reset = 1'b0;
        mem_valid = 1'b1; mem_rdata = 64'h1111_2222_3333_4444;
        @(negedge clk);
        mem_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("wrst_no_out_valid", {ov32, ov64}, 2'b00);
            check("wrst_idle", {rr32, rr64}, 2'b11);
            @(negedge clk);
        end

        for (int i = 0; i < 40; i++) begin
            c   = ($urandom_range(0, 7) == 0) ? 2'b00 : 2'($urandom_range(1, 3));
            s   = 1'($urandom);
            a   = 3'($urandom);
            if ($urandom_range(0, 1) == 1) begin
                if (c == 2'b01) a = a & 3'b100;
                if (c == 2'b10) a = a & 3'b110;
            end
            rd  = {$urandom, $urandom};
            dly = $urandom_range(0, 5);
            bp  = $urandom_range(0, 2);
            r32 = model(32, c, s, a, rd, dly);
            r64 = model(64, c, s, a, rd, dly);
            run_load(c, s, a, rd, dly, bp, r64[65:64], r32[31:0], r64[63:0]);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule

// File: doc/load_align_unit.md
LOAD_ALIGN_UNIT -- requirements
Module: load_align_unit

Interface
- REQ-001 SHALL have parameter DATA_W, default 32, memory read-data width in bits; legal values 32 and 64.
- REQ-002 SHALL have parameter TIMEOUT, default 16, maximum WAIT_MEM cycles before the timeout error; legal range 1..255.
- REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on rising edge.
- REQ-004 SHALL have port reset, input, 1, asynchronous active-high reset.
- REQ-005 SHALL have port req_valid, input, 1, load request present.
- REQ-006 SHALL have port req_ready, output, 1, high exactly when the state is IDLE.
- REQ-007 SHALL have port LSCtrl, input, 2, load size: 01 word, 10 halfword, 11 byte, 00 illegal.
- REQ-008 SHALL have port ls_signed, input, 1, 1 = sign-extend, 0 = zero-extend.
- REQ-009 SHALL have port addr_lo, input, clog2(DATA_W/8), byte offset within the memory word.
- REQ-010 SHALL have port mem_valid, input, 1, mem_rdata valid this cycle.
- REQ-011 SHALL have port mem_rdata, input, DATA_W, raw memory word.
- REQ-012 SHALL have port out_valid, output, 1, result available.
- REQ-013 SHALL have port out_ready, input, 1, consumer accepts result.
- REQ-014 SHALL have port data_out, output, DATA_W, aligned and extended load result.
- REQ-015 SHALL have port err, output, 2, completion status: 00 ok, 01 misaligned, 10 timeout, 11 illegal size.

Function
- REQ-016 SHALL implement an FSM with states IDLE, WAIT_MEM and DONE.
- REQ-017 SHALL accept a request when req_valid and req_ready are both high, and register LSCtrl, ls_signed and addr_lo at acceptance.
- REQ-018 SHALL check the request at acceptance:
  - LSCtrl=00 -> DONE with err=11.
  - word with addr_lo[1:0]!=0 -> DONE with err=01.
  - halfword with addr_lo[0]!=0 -> DONE with err=01.
  - otherwise -> WAIT_MEM.
- REQ-019 SHALL drive data_out=0 on every error completion.
- REQ-020 SHALL ignore mem_valid in IDLE and DONE.
- REQ-021 SHALL, in WAIT_MEM with mem_valid=1, register the field of mem_rdata selected by little-endian lane addr_lo, extended to DATA_W, set err=00, and go to DONE.
  - Word lane is mem_rdata[32*addr_lo[n:2] +: 32].
  - Halfword lane is mem_rdata[8*addr_lo +: 16].
  - Byte lane is mem_rdata[8*addr_lo +: 8].
- REQ-022 SHALL, in WAIT_MEM with mem_valid=0, increment a wait counter, and go to DONE with err=10 when the counter reaches TIMEOUT.
- REQ-023 SHALL give mem_valid priority over timeout when both occur in the same cycle.
- REQ-024 SHALL clear the wait counter on every request acceptance.
- REQ-025 SHALL assert out_valid exactly in DONE, holding data_out and err stable until out_ready=1; then go to IDLE.
- REQ-026 SHALL produce out_valid one cycle after the mem_valid cycle, or one cycle after acceptance for error completions.
- REQ-027 SHALL accept a new request no earlier than the cycle after the DONE->IDLE handshake; maximum throughput is one load per 3 cycles.

Reset
- REQ-028 SHALL, on reset=1, immediately force state IDLE with req_ready=1, out_valid=0, data_out=0, err=00 and wait counter 0, regardless of clk.
- REQ-029 SHALL discard any in-flight request on reset; a mem_valid arriving after reset release SHALL be ignored.

Structure
- REQ-030 SHALL take the following from a shared package (load_pkg): the LSCtrl encodings, the err codes and the FSM state type.
- REQ-031 SHALL place lane select and extension in one combinational sub-module, load_extract, with inputs mem_rdata, LSCtrl, ls_signed and addr_lo, and output the extended data.

Verification
- REQ-032 SHALL cover a signed byte load: DATA_W=32, byte, ls_signed=1, addr_lo=2, mem_rdata=0x12_80_34_56 -> data_out=0xFFFFFF80, err=00.
- REQ-033 SHALL cover a misaligned halfword load: addr_lo=1 -> out_valid on the cycle after acceptance, err=01, data_out=0, mem_valid ignored.
- REQ-034 SHALL cover timeout: TIMEOUT=4, mem_valid never asserted -> err=10 exactly 4 cycles after acceptance; mem_valid arriving on the 4th wait cycle instead -> err=00 with data.
- REQ-035 SHALL cover a word load on the upper lane: DATA_W=64, word, ls_signed=0, addr_lo=4, mem_rdata=0x8000_0001_0000_0000 -> data_out=0x0000_0000_8000_0001.
- REQ-036 SHALL cover backpressure: out_ready held 0 for 5 cycles -> data_out and err stable, req_ready=0 throughout.
- REQ-037 SHALL cover reset during WAIT_MEM: outputs return to reset values immediately, and a subsequent mem_valid produces no out_valid.
